// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control sequencer: op classes,
// R-type function codes, ALU control codes and the sequencer state type.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_NOR  = 6'b100111;

  localparam logic [3:0] CODE_AND  = 4'b0000;
  localparam logic [3:0] CODE_OR   = 4'b0001;
  localparam logic [3:0] CODE_ADD  = 4'b0010;
  localparam logic [3:0] CODE_XOR  = 4'b0100;
  localparam logic [3:0] CODE_MULT = 4'b0101;
  localparam logic [3:0] CODE_SUB  = 4'b0110;
  localparam logic [3:0] CODE_SLT  = 4'b0111;
  localparam logic [3:0] CODE_SLL  = 4'b1000;
  localparam logic [3:0] CODE_SRL  = 4'b1001;
  localparam logic [3:0] CODE_SRA  = 4'b1010;
  localparam logic [3:0] CODE_DIV  = 4'b1011;
  localparam logic [3:0] CODE_NOR  = 4'b1100;

  typedef enum logic {ST_IDLE, ST_MULTI} state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {ALUOp, Function} decode into ALU code, illegal flag and
// a marker for operations that need the multi-cycle sequencer.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNC_W = 6
) (
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] funct,
  output logic [3:0]        code,
  output logic              illegal,
  output logic              is_multi
);

  // Unknown R-type functions fall back to the AND code and raise illegal.
  always_comb begin
    code     = CODE_AND;
    illegal  = 1'b0;
    is_multi = 1'b0;
    case (alu_op)
      ALUOP_ADD: code = CODE_ADD;
      ALUOP_SUB: code = CODE_SUB;
      ALUOP_AND: code = CODE_AND;
      default: begin
        case (funct)
          FUNC_W'(FN_AND):  code = CODE_AND;
          FUNC_W'(FN_OR):   code = CODE_OR;
          FUNC_W'(FN_ADD):  code = CODE_ADD;
          FUNC_W'(FN_XOR):  code = CODE_XOR;
          FUNC_W'(FN_SUB):  code = CODE_SUB;
          FUNC_W'(FN_SLT):  code = CODE_SLT;
          FUNC_W'(FN_SLL):  code = CODE_SLL;
          FUNC_W'(FN_SRL):  code = CODE_SRL;
          FUNC_W'(FN_SRA):  code = CODE_SRA;
          FUNC_W'(FN_NOR):  code = CODE_NOR;
          FUNC_W'(FN_MULT): begin
            code     = CODE_MULT;
            is_multi = 1'b1;
          end
          FUNC_W'(FN_DIV): begin
            code     = CODE_DIV;
            is_multi = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control with a down-counting latency timer for mult/div,
// so the EX stage can stall on Ready_out and consume results on Valid_out.
//
//   state    | meaning
//   ST_IDLE  | accepting ops; single-cycle results pulse Valid_out next cycle
//   ST_MULTI | mult/div in flight; count runs down to 0, then Valid_out pulses
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNC_W   = 6,
  parameter int CTRL_W   = 4,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Valid_in,
  input  logic [1:0]        ALUOp,
  input  logic [FUNC_W-1:0] Function,
  input  logic              Flush,
  output logic              Ready_out,
  output logic [CTRL_W-1:0] ALU_Control,
  output logic              Valid_out,
  output logic              Busy,
  output logic              Illegal
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               illegal_q, illegal_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic [3:0]         dec_code;
  logic               dec_illegal;
  logic               dec_multi;
  logic               accept;

  alu_ctrl_decode #(.FUNC_W(FUNC_W)) u_decode (
    .alu_op   (ALUOp),
    .funct    (Function),
    .code     (dec_code),
    .illegal  (dec_illegal),
    .is_multi (dec_multi)
  );

  assign Ready_out   = (state_q == ST_IDLE);
  assign accept      = Valid_in & Ready_out & ~Flush;
  assign ALU_Control = ctrl_q;
  assign Illegal     = illegal_q;
  assign Valid_out   = valid_q;
  assign Busy        = busy_q;

  // Next-state: Flush wins over everything; the result code is captured on
  // every accept and held through flushes until the next accept.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    if (Flush) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ctrl_d    = CTRL_W'(dec_code);
            illegal_d = dec_illegal;
            if (dec_multi) begin
              busy_d  = 1'b1;
              state_d = ST_MULTI;
              count_d = (dec_code == CODE_MULT) ? MULT_LOAD : DIV_LOAD;
            end else begin
              valid_d = 1'b1;
            end
          end
        end
        ST_MULTI: begin
          if (count_q == '0) begin
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: two instances (DIV_LAT 16 and 2) share one
// stimulus stream; a timestamp-based reference model is compared every cycle.
module tb_alu_control_seq;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       flush;

  logic [1:0] rdy, vout, busy, ill;
  logic [3:0] ctrl [2];

  int n_cmp  = 0;
  int n_fail = 0;

  alu_control_seq #(.FUNC_W(6), .CTRL_W(4), .MULT_LAT(4), .DIV_LAT(16)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .Valid_in(valid_in), .ALUOp(alu_op),
    .Function(funct), .Flush(flush), .Ready_out(rdy[0]),
    .ALU_Control(ctrl[0]), .Valid_out(vout[0]), .Busy(busy[0]), .Illegal(ill[0]));

  alu_control_seq #(.FUNC_W(6), .CTRL_W(4), .MULT_LAT(4), .DIV_LAT(2)) dut1 (
    .Clk(clk), .Reset_n(rst_n), .Valid_in(valid_in), .ALUOp(alu_op),
    .Function(funct), .Flush(flush), .Ready_out(rdy[1]),
    .ALU_Control(ctrl[1]), .Valid_out(vout[1]), .Busy(busy[1]), .Illegal(ill[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode table: funct -> code, and latency class (0 single, 1 mult, 2 div).
  logic [5:0] tbl_fn   [12] = '{6'b100100, 6'b100101, 6'b100000, 6'b100110,
                                6'b011000, 6'b100010, 6'b101010, 6'b000000,
                                6'b000010, 6'b000011, 6'b011010, 6'b100111};
  logic [3:0] tbl_code [12] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6,
                                4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
  int         tbl_kind [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0};
  int         div_lat  [2]  = '{16, 2};

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                     output logic [3:0] code, output bit illg,
                                     output int kind);
    code = 4'h0; illg = 1'b0; kind = 0;
    if (op == 2'b00) code = 4'h2;
    else if (op == 2'b01) code = 4'h6;
    else if (op == 2'b11) code = 4'h0;
    else begin
      illg = 1'b1;
      for (int k = 0; k < 12; k++)
        if (tbl_fn[k] == fn) begin
          code = tbl_code[k]; kind = tbl_kind[k]; illg = 1'b0;
        end
    end
  endfunction

  // Model state: expected outputs plus the edge number at which a pending
  // multi-cycle result completes (-1 when nothing is in flight).
  int         edge_n = 0;
  int         done_at [2] = '{-1, -1};
  logic [3:0] m_ctrl  [2] = '{4'h0, 4'h0};
  bit         m_ill   [2] = '{0, 0};
  bit         m_vout  [2] = '{0, 0};
  bit         m_busy  [2] = '{0, 0};
  bit         checking = 1'b0;

  always @(posedge clk) begin
    logic [3:0] c;
    bit         il;
    int         kind;
    edge_n++;
    ref_decode(alu_op, funct, c, il, kind);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_ctrl[i] = 4'h0; m_ill[i] = 1'b0; m_vout[i] = 1'b0; m_busy[i] = 1'b0;
        done_at[i] = -1;
      end else if (flush) begin
        m_vout[i] = 1'b0; m_busy[i] = 1'b0; done_at[i] = -1;
      end else if (done_at[i] >= 0) begin
        if (edge_n == done_at[i]) begin
          m_vout[i] = 1'b1; m_busy[i] = 1'b0; done_at[i] = -1;
        end else begin
          m_vout[i] = 1'b0; m_busy[i] = 1'b1;
        end
      end else if (valid_in) begin
        m_ctrl[i] = c; m_ill[i] = il;
        if (kind == 0) begin
          m_vout[i] = 1'b1;
        end else begin
          done_at[i] = edge_n + ((kind == 1) ? 4 : div_lat[i]);
          m_vout[i] = 1'b0; m_busy[i] = 1'b1;
        end
      end else begin
        m_vout[i] = 1'b0;
      end
    end
    checking = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model.ctrl[%0d]", i),    32'(ctrl[i]), 32'(m_ctrl[i]));
        chk($sformatf("model.illegal[%0d]", i), 32'(ill[i]),  32'(m_ill[i]));
        chk($sformatf("model.valid[%0d]", i),   32'(vout[i]), 32'(m_vout[i]));
        chk($sformatf("model.busy[%0d]", i),    32'(busy[i]), 32'(m_busy[i]));
        chk($sformatf("model.ready[%0d]", i),   32'(rdy[i]),  32'(done_at[i] < 0));
      end
    end
  end

  task automatic apply(input bit v, input logic [1:0] op, input logic [5:0] fn,
                       input bit fl, input bit rn);
    valid_in = v; alu_op = op; funct = fn; flush = fl; rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] s_fn   [12] = '{6'b100000, 6'b100010, 6'b101010, 6'b000011,
                              6'b100100, 6'b100101, 6'b100110, 6'b000000,
                              6'b000010, 6'b100111, 6'b100000, 6'b100000};
  logic [1:0] s_op   [12] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
  logic [3:0] s_exp  [12] = '{4'h2, 4'h6, 4'h7, 4'hA, 4'h0, 4'h1,
                              4'h4, 4'h8, 4'h9, 4'hC, 4'h2, 4'h6};

  initial begin
    int lat, l0, l1, pulses;
    logic [3:0] c0, c1;
    valid_in = 1'b1; alu_op = 2'b00; funct = 6'h0; flush = 1'b0; rst_n = 1'b0;

    apply(1, 2'b00, 6'h00, 0, 0);
    apply(1, 2'b00, 6'h00, 0, 0);
    chk("reset.ready", 32'(rdy[0]), 1);
    chk("reset.ctrl",  32'(ctrl[0]), 0);
    chk("reset.valid", 32'(vout[0]), 0);
    chk("reset.busy",  32'(busy[0]), 0);
    apply(0, 2'b00, 6'h00, 0, 1);
    apply(0, 2'b00, 6'h00, 0, 1);
    chk("idle.valid", 32'(vout[0]), 0);
    chk("idle.ctrl",  32'(ctrl[0]), 0);

    for (int i = 0; i < 12; i++) begin
      apply(1, s_op[i], s_fn[i], 0, 1);
      chk($sformatf("stream%0d.ctrl", i),  32'(ctrl[0]), 32'(s_exp[i]));
      chk($sformatf("stream%0d.valid", i), 32'(vout[0]), 1);
    end
    apply(1, 2'b11, 6'b100000, 0, 1);
    chk("aluop11.ctrl", 32'(ctrl[0]), 0);
    apply(0, 2'b00, 6'h00, 0, 1);

    apply(1, 2'b10, 6'b011000, 0, 1);
    chk("mult.busy",  32'(busy[0]), 1);
    chk("mult.ready", 32'(rdy[0]), 0);
    chk("mult.valid", 32'(vout[0]), 0);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      apply(1, 2'b00, 6'h00, 0, 1);
      if (vout[0]) begin lat = i; break; end
    end
    chk("mult.latency", 32'(lat), 4);
    chk("mult.ctrl", 32'(ctrl[0]), 4'h5);
    apply(1, 2'b00, 6'h00, 0, 1);
    chk("held_add.valid", 32'(vout[0]), 1);
    chk("held_add.ctrl",  32'(ctrl[0]), 4'h2);
    apply(0, 2'b00, 6'h00, 0, 1);

    apply(1, 2'b10, 6'b011010, 0, 1);
    l0 = 0; l1 = 0; c0 = 4'h0; c1 = 4'h0;
    for (int i = 1; i <= 40; i++) begin
      apply(0, 2'b00, 6'h00, 0, 1);
      if (vout[0] && l0 == 0) begin l0 = i; c0 = ctrl[0]; end
      if (vout[1] && l1 == 0) begin l1 = i; c1 = ctrl[1]; end
      if (l0 != 0 && l1 != 0) break;
    end
    chk("div16.latency", 32'(l0), 16);
    chk("div2.latency",  32'(l1), 2);
    chk("div16.ctrl", 32'(c0), 4'hB);
    chk("div2.ctrl",  32'(c1), 4'hB);

    apply(1, 2'b10, 6'b011010, 0, 1);
    apply(0, 2'b00, 6'h00, 0, 1);
    apply(0, 2'b00, 6'h00, 0, 1);
    apply(0, 2'b00, 6'h00, 1, 1);
    chk("flush.busy",  32'(busy[0]), 0);
    chk("flush.ready", 32'(rdy[0]), 1);
    chk("flush.valid", 32'(vout[0]), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      apply(0, 2'b00, 6'h00, 0, 1);
      if (vout[0]) pulses++;
    end
    chk("flush.no_late_valid", 32'(pulses), 0);

    apply(1, 2'b00, 6'h00, 1, 1);
    chk("flush_idle.valid", 32'(vout[0]), 0);
    chk("flush_idle.ctrl_held", 32'(ctrl[0]), 4'hB);
    apply(0, 2'b00, 6'h00, 0, 1);

    apply(1, 2'b10, 6'b011000, 0, 1);
    apply(0, 2'b00, 6'h00, 0, 1);
    apply(0, 2'b00, 6'h00, 0, 0);
    chk("rst_mid.ctrl",  32'(ctrl[0]), 0);
    chk("rst_mid.busy",  32'(busy[0]), 0);
    chk("rst_mid.ready", 32'(rdy[0]), 1);
    apply(0, 2'b00, 6'h00, 0, 1);
    apply(0, 2'b00, 6'h00, 0, 1);
    apply(0, 2'b00, 6'h00, 0, 1);
    apply(0, 2'b00, 6'h00, 0, 1);
    chk("rst_mid.no_valid", 32'(vout[0]), 0);

    apply(1, 2'b10, 6'b111111, 0, 1);
    chk("illegal.ctrl",  32'(ctrl[0]), 0);
    chk("illegal.flag",  32'(ill[0]), 1);
    chk("illegal.valid", 32'(vout[0]), 1);
    apply(1, 2'b10, 6'b100101, 0, 1);
    chk("legal_after.flag", 32'(ill[0]), 0);
    chk("legal_after.ctrl", 32'(ctrl[0]), 4'h1);
    apply(0, 2'b00, 6'h00, 0, 1);
    apply(0, 2'b00, 6'h00, 0, 1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
